// File: rtl/bp_stats_pkg.sv
// Shared types and constants for the branch-prediction statistics monitor.
//   bp_state_e    : monitor phase (RUN -> DRAIN -> DONE)
//   HALT_INSN_DEF : default program-end encoding (jal x0,0)
package bp_stats_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } bp_state_e;

    localparam logic [PC_W-1:0] HALT_INSN_DEF = 32'h0000_006F;

endpackage

// File: rtl/bp_stats_monitor_if.sv
// Miss-log drain port: valid/ready stream of mispredicted PCs.
//   log_vld : log head is valid (producer)
//   log_pc  : PC at the log head (producer)
//   log_rdy : consumer accepts the head this cycle (consumer)
interface bp_stats_monitor_if;
    import bp_stats_pkg::*;

    logic            log_vld;
    logic [PC_W-1:0] log_pc;
    logic            log_rdy;

    modport master (output log_vld, output log_pc, input log_rdy);
    modport slave  (input log_vld, input log_pc, output log_rdy);

endinterface

// File: rtl/bp_miss_fifo.sv
// Synchronous FIFO with valid/ready pop, drop-on-full push and sticky overflow.
//   clk_i/rst_i : clock, async active-high reset
//   clr_i       : synchronous flush (also clears overflow)
//   push_i/push_data_i : write request and data (dropped when full w/o pop)
//   pop_rdy_i   : consumer ready; a pop happens on vld_o && pop_rdy_i
//   vld_o/data_o: registered non-empty flag and head data
//   ovf_o       : sticky, a push was dropped
module bp_miss_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_rdy_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q, wr_d, rd_d;
    logic              vld_q, ovf_q;
    logic [DATA_W-1:0] data_q;
    logic              full_c, pop_c, wen_c, fwd_c;

    assign full_c = (wr_q - rd_q) == PTR_W'(DEPTH);
    assign pop_c  = vld_q && pop_rdy_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign wen_c  = push_i && (!full_c || pop_c);
    assign wr_d   = wr_q + PTR_W'(wen_c);
    assign rd_d   = rd_q + PTR_W'(pop_c);
    // Next head is the entry being written this cycle
    assign fwd_c  = wen_c && (rd_d[IDX_W-1:0] == wr_q[IDX_W-1:0]);

    // Pointer, head and flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else if (clr_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            vld_q <= (wr_d != rd_d);
            if (wr_d != rd_d) begin
                data_q <= fwd_c ? push_data_i : mem_q[rd_d[IDX_W-1:0]];
            end
            if (push_i && !wen_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (wen_c && !clr_i) begin
            mem_q[wr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/bp_stats_monitor.sv
// Branch-prediction statistics collector with halt detection and miss log.
//   clk_i/rst_i    : clock, async active-high reset
//   br_instr_i     : branch resolved this cycle; br_miss_i: it was mispredicted
//   pc_i           : PC of the resolved branch; instr_i: instruction in IF
//   clear_i        : synchronous clear of all statistics, back to RUN
//   log_if         : miss-log drain port (valid/ready)
//   log_ovf_o      : sticky miss-log overflow
//   cyc/br/miss_cnt_o : saturating totals
//   win_miss_o/win_vld_o : misses in last completed window, update pulse
//   done_o         : statistics frozen after program end
module bp_stats_monitor
    import bp_stats_pkg::*;
#(
    parameter int unsigned     CNT_W     = 32,
    parameter int unsigned     WINDOW    = 256,
    parameter int unsigned     LOG_DEPTH = 8,
    parameter logic [PC_W-1:0] HALT_INSN = HALT_INSN_DEF,
    parameter int unsigned     DRAIN_CYC = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    br_instr_i,
    input  logic                    br_miss_i,
    input  logic [PC_W-1:0]         pc_i,
    input  logic [PC_W-1:0]         instr_i,
    input  logic                    clear_i,
    bp_stats_monitor_if.master      log_if,
    output logic                    log_ovf_o,
    output logic [CNT_W-1:0]        cyc_cnt_o,
    output logic [CNT_W-1:0]        br_cnt_o,
    output logic [CNT_W-1:0]        miss_cnt_o,
    output logic [$clog2(WINDOW):0] win_miss_o,
    output logic                    win_vld_o,
    output logic                    done_o
);
    localparam int unsigned IDX_W = $clog2(WINDOW);
    localparam int unsigned ACC_W = IDX_W + 1;
    localparam int unsigned DC_W  = $clog2(DRAIN_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    bp_state_e         state_q;
    logic [DC_W-1:0]   drain_q;
    logic [CNT_W-1:0]  cyc_q, br_q, miss_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ACC_W-1:0]  acc_q, win_miss_q;
    logic              win_vld_q, done_q;
    logic              qmiss_c, push_c;

    assign qmiss_c = br_instr_i && br_miss_i;
    assign push_c  = qmiss_c && (state_q != ST_DONE) && !clear_i;

    // Phase tracking, saturating counters and window accounting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            drain_q    <= '0;
            cyc_q      <= '0;
            br_q       <= '0;
            miss_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            win_miss_q <= '0;
            win_vld_q  <= 1'b0;
            done_q     <= 1'b0;
        end else if (clear_i) begin
            state_q    <= ST_RUN;
            drain_q    <= '0;
            cyc_q      <= '0;
            br_q       <= '0;
            miss_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            win_miss_q <= '0;
            win_vld_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            win_vld_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (instr_i == HALT_INSN) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DC_W'(DRAIN_CYC - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DC_W'(1);
                    end
                end
                default: ;
            endcase

            if (state_q != ST_DONE) begin
                if (cyc_q != CNT_MAX) cyc_q <= cyc_q + CNT_W'(1);
                if (br_instr_i && (br_q != CNT_MAX)) br_q <= br_q + CNT_W'(1);
                if (qmiss_c && (miss_q != CNT_MAX)) miss_q <= miss_q + CNT_W'(1);
                if (br_instr_i) begin
                    // Last branch of the window closes it, including its own miss
                    if (idx_q == IDX_W'(WINDOW - 1)) begin
                        win_miss_q <= acc_q + ACC_W'(qmiss_c);
                        win_vld_q  <= 1'b1;
                        idx_q      <= '0;
                        acc_q      <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        acc_q <= acc_q + ACC_W'(qmiss_c);
                    end
                end
            end
        end
    end

    bp_miss_fifo #(
        .DEPTH  (LOG_DEPTH),
        .DATA_W (PC_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clear_i),
        .push_i      (push_c),
        .push_data_i (pc_i),
        .pop_rdy_i   (log_if.log_rdy),
        .vld_o       (log_if.log_vld),
        .data_o      (log_if.log_pc),
        .ovf_o       (log_ovf_o)
    );

    assign cyc_cnt_o  = cyc_q;
    assign br_cnt_o   = br_q;
    assign miss_cnt_o = miss_q;
    assign win_miss_o = win_miss_q;
    assign win_vld_o  = win_vld_q;
    assign done_o     = done_q;

endmodule
